// File: rtl/spi_aes_port.sv
// SPI front end for an AES core: deserializes data+key, starts the core, shifts the result back out.
// Define SPI_CS_ABORT_EN to make CS deassertion abort RECV/SEND instead of pausing them.
module spi_aes_port #(
    parameter int NK    = 4,
    parameter int FRAME = 128 + NK * 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              SDI,
    output logic              SDO,
    output logic [127:0]      core_data,
    output logic [NK*32-1:0]  core_key,
    output logic              core_start,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              frame_done
);

    localparam int CW = $clog2(FRAME + 1);

`ifdef SPI_CS_ABORT_EN
    localparam logic CS_ABORT = 1'b1;
`else
    localparam logic CS_ABORT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [127:0]     tx;
    logic [FRAME-2:0] rx;
    logic [FRAME-1:0] frame_w;
    logic             rx_last;
    logic             tx_last;

    // frame_w is the complete frame as it stands once the current SDI bit lands
    assign frame_w = {rx, SDI};
    assign rx_last = (cnt == CW'(FRAME - 1));
    assign tx_last = (cnt == CW'(127));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!CS) state_nxt = RECV;
            RECV: begin
                if (CS) begin
                    if (CS_ABORT) state_nxt = IDLE;
                end else if (rx_last) begin
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT:  if (core_done) state_nxt = SEND;
            SEND: begin
                if (CS) begin
                    if (CS_ABORT) state_nxt = IDLE;
                end else if (tx_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:  if (CS) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start = 1'b0;
        frame_done = 1'b0;
        SDO        = 1'b0;
        case (state)
            START:   core_start = 1'b1;
            SEND:    SDO        = tx[127];
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Receive shifter is fully overwritten by every frame, so it carries no reset
    always_ff @(posedge clk) begin
        if ((state == IDLE || state == RECV) && !CS) begin
            rx <= frame_w[FRAME-2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tx        <= '0;
            core_data <= '0;
            core_key  <= '0;
        end else begin
            case (state)
                IDLE: cnt <= CS ? '0 : CW'(1);
                RECV: begin
                    if (CS) begin
                        if (CS_ABORT) cnt <= '0;
                    end else if (rx_last) begin
                        cnt       <= '0;
                        core_data <= frame_w[FRAME-1 -: 128];
                        core_key  <= frame_w[NK*32-1:0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        tx  <= core_result;
                        cnt <= '0;
                    end
                end
                SEND: begin
                    if (CS) begin
                        if (CS_ABORT) begin
                            cnt <= '0;
                            tx  <= '0;
                        end
                    end else begin
                        tx  <= {tx[126:0], 1'b0};
                        cnt <= tx_last ? '0 : cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_aes_port.sv
// Directed bench for spi_aes_port: NK=4 instance for the full transaction flow, NK=8 instance for long keys.
module tb_spi_aes_port;

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] D2 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] K2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         rst;
    logic         cs, sdi, sdo;
    logic [127:0] core_data;
    logic [127:0] core_key;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_result;
    logic         frame_done;

    logic         cs8, sdi8, sdo8;
    logic [127:0] data8;
    logic [255:0] key8;
    logic         start8;
    logic         done8;
    logic [127:0] result8;
    logic         frame_done8;

    int tests;
    int fails;

    spi_aes_port #(.NK(4)) dut (
        .clk(clk), .rst(rst), .CS(cs), .SDI(sdi), .SDO(sdo),
        .core_data(core_data), .core_key(core_key), .core_start(core_start),
        .core_done(core_done), .core_result(core_result), .frame_done(frame_done)
    );

    spi_aes_port #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .CS(cs8), .SDI(sdi8), .SDO(sdo8),
        .core_data(data8), .core_key(key8), .core_start(start8),
        .core_done(done8), .core_result(result8), .frame_done(frame_done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Streams nbits of fr (MSB first) into the selected instance, one bit per rising edge
    task automatic shift_in(input bit sel, input logic [383:0] fr, input int nbits,
                            input int pause_at, input int inject_at, output bit early);
        early = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (sel) begin
                cs8 = 1'b0; sdi8 = fr[nbits-1-i];
            end else begin
                cs = 1'b0; sdi = fr[nbits-1-i];
            end
            if (i == inject_at) begin
                core_done = 1'b1; core_result = ~R1;
            end
            @(negedge clk);
            core_done = 1'b0; core_result = '0;
            if (i == inject_at) check("sdo_after_inject", sdo, 1'b0);
            if (i < nbits - 1 && (sel ? start8 : core_start)) early = 1'b1;
            if (i == pause_at) begin
                if (sel) cs8 = 1'b1; else cs = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input logic [127:0] d, input logic [127:0] k, input logic [127:0] r,
                             input int pause_at, input int inject_at, input int rst_at);
        logic [127:0] got;
        bit           early;
        shift_in(1'b0, {128'b0, d, k}, 256, pause_at, inject_at, early);
        check("no_early_start", early, 1'b0);
        check("start_pulse", core_start, 1'b1);
        check("core_data", core_data, d);
        check("core_key", core_key, k);
        @(negedge clk);
        check("start_single", core_start, 1'b0);
        repeat (9) @(negedge clk);
        check("sdo_wait", sdo, 1'b0);
        core_done = 1'b1; core_result = r;
        @(negedge clk);
        core_done = 1'b0; core_result = '0;
        got = '0;
        for (int i = 0; i < 128; i++) begin
            if (i == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_sdo", sdo, 1'b0);
                check("rst_frame_done", frame_done, 1'b0);
                check("rst_core_data", core_data, 128'b0);
                check("rst_core_key", core_key, 128'b0);
                cs = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            got = {got[126:0], sdo};
            @(negedge clk);
        end
        check("sdo_result", got, r);
        check("frame_done", frame_done, 1'b1);
        repeat (3) @(negedge clk);
        check("frame_done_hold", frame_done, 1'b1);
        cs = 1'b1;
        @(negedge clk);
        check("frame_done_clear", frame_done, 1'b0);
    endtask

    initial begin
        bit early8;
        tests = 0; fails = 0;
        rst = 1'b1; cs = 1'b1; sdi = 1'b0; cs8 = 1'b1; sdi8 = 1'b0;
        core_done = 1'b0; core_result = '0; done8 = 1'b0; result8 = '0;
        #3;
        check("reset_sdo", sdo, 1'b0);
        check("reset_start", core_start, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_core_data", core_data, 128'b0);
        check("reset_core_key", core_key, 128'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer transaction
        run_frame(D1, K1, R1, -1, -1, -1);
        // Stray core_done during receive
        run_frame(D2, K2, R2, -1, 50, -1);

`ifdef SPI_CS_ABORT_EN
        shift_in(1'b0, {128'b0, D1, K1}, 101, -1, -1, early8);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_start", core_start, 1'b0);
        check("abort_core_data", core_data, D2);
        check("abort_core_key", core_key, K2);
        check("abort_sdo", sdo, 1'b0);
        run_frame(D1, K1, R1, -1, -1, -1);
`else
        run_frame(D1, K1, R1, 100, -1, -1);
`endif

        // Reset in the middle of the result shift-out, then a clean frame
        run_frame(D2, K2, R2, -1, -1, 60);
        check("post_rst_sdo", sdo, 1'b0);
        run_frame(D1, K1, R1, -1, -1, -1);

        // 256-bit key instance
        shift_in(1'b1, {D1, K8}, 384, -1, -1, early8);
        check("nk8_no_early_start", early8, 1'b0);
        check("nk8_start_pulse", start8, 1'b1);
        check("nk8_core_data", data8, D1);
        check("nk8_core_key", key8, K8);
        @(negedge clk);
        check("nk8_start_single", start8, 1'b0);
        check("nk8_sdo_wait", sdo8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
